// File: rtl/cnt_stream_pkg.sv
// Shared types for the counter-whitened stream decoder.
package cnt_stream_pkg;

   typedef enum logic {SEEK, RUN} dec_state_t;

   localparam int DATA_W_DEF = 8;

   typedef logic [DATA_W_DEF-1:0] byte_t;

endpackage

// File: rtl/cnt_stream_fifo.sv
// Synchronous FIFO with occupancy counter; head data reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cnt_stream_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       used;
   logic              do_push;
   logic              do_pop;

   assign full     = (used == (AW+1)'(DEPTH));
   assign empty    = (used == '0);
   assign do_pop   = pop & ~empty & ~clr;
   assign do_push  = push & (~full | do_pop) & ~clr;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   used <= used + 1'b1;
            2'b01:   used <= used - 1'b1;
            default: used <= used;
         endcase
      end
   end

   // NOTE: storage is not reset; stale entries are never visible because
   // pop_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cnt_stream_decoder.sv
// Counter-whitened stream decoder: removes the running count and buffers payload.
// Optional drop statistics counter enabled by CNT_STREAM_DECODER_STATS_EN.
module cnt_stream_decoder
   import cnt_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_sync,
   input  logic              clr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              locked,
`ifdef CNT_STREAM_DECODER_STATS_EN
   output logic [15:0]       drop_cnt,
`endif
   output logic              ovf
);

   dec_state_t        state;
   logic [DATA_W-1:0] count;
   logic              accept;
   logic              is_run;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic              ovf_drop;

   assign accept    = in_valid & ~clr;
   assign is_run    = (state == RUN);
   assign push      = accept & (is_run | in_sync);
   assign push_data = in_sync ? in_data : in_data - count;
   // Full means non-empty, so only a missing out_ready can cause a drop.
   assign ovf_drop  = push & fifo_full & ~out_ready;
   assign out_valid = ~fifo_empty;
   assign locked    = is_run;

   cnt_stream_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (push),
      .push_data (push_data),
      .pop       (out_ready),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEEK;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         state <= SEEK;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (accept && in_sync) begin
            state <= RUN;
            count <= DATA_W'(1);
         end else if (accept && is_run) begin
            count <= count + 1'b1;
         end
         if (ovf_drop) ovf <= 1'b1;
      end
   end

`ifdef CNT_STREAM_DECODER_STATS_EN
   logic seek_drop;

   assign seek_drop = accept & ~is_run & ~in_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (clr) begin
         drop_cnt <= '0;
      end else if ((seek_drop || ovf_drop) && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cnt_stream_decoder.sv
// Scoreboard bench for cnt_stream_decoder; drop_cnt checks follow CNT_STREAM_DECODER_STATS_EN.
module tb_cnt_stream_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_sync = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       locked;
   logic       ovf;
`ifdef CNT_STREAM_DECODER_STATS_EN
   logic [15:0] drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   cnt_stream_decoder #(.DATA_W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
`ifdef CNT_STREAM_DECODER_STATS_EN
      .drop_cnt  (drop_cnt),
`endif
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a beat is consumed on every edge where out_valid & out_ready.
   always @(negedge clk) begin
      if (rst_n && !clr && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_data), 32'hDEAD);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_sync  = s;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = '0;
   endtask

   int n;

   initial begin
      // Reset state
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_ovf", 32'(ovf), 0);
      step();
      rst_n = 1'b1;
      step();

      // 1: unsynchronised bytes are discarded
      send(8'h10, 1'b0);
      send(8'h11, 1'b0);
      idle();
      step();
      check("t1_out_valid", 32'(out_valid), 0);
      check("t1_locked", 32'(locked), 0);
`ifdef CNT_STREAM_DECODER_STATS_EN
      check("t1_drop_cnt", 32'(drop_cnt), 2);
`endif

      // 2: sync then back-to-back stream, all decode to 0x05
      out_ready = 1'b1;
      exp_q.push_back(8'h05);
      send(8'h05, 1'b1);
      check("t2_latency_valid", 32'(out_valid), 1);
      check("t2_latency_data", 32'(out_data), 32'h05);
      check("t2_locked", 32'(locked), 1);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'h05);
         send(8'h06 + 8'(i), 1'b0);
      end
      idle();
      repeat (3) step();

      // 3: count wraps 0xFF->0x00; every byte decodes to 0x02
      exp_q.push_back(8'h02);
      send(8'h02, 1'b1);
      for (int c = 1; c <= 8'hFD; c++) begin
         exp_q.push_back(8'h02);
         send(8'(c + 2), 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'h02);
         send(8'(i), 1'b0);
      end
      idle();
      repeat (3) step();
      check("t3_drained", 32'(exp_q.size()), 0);

      // 4: backpressure, payloads 0x10..0x50 with count 0..4; fifth dropped
      out_ready = 1'b0;
      exp_q.push_back(8'h10);
      send(8'h10, 1'b1);
      exp_q.push_back(8'h20);
      send(8'h21, 1'b0);
      exp_q.push_back(8'h30);
      send(8'h32, 1'b0);
      exp_q.push_back(8'h40);
      send(8'h43, 1'b0);
      send(8'h54, 1'b0);
      idle();
      check("t4_ovf", 32'(ovf), 1);
      check("t4_full_valid", 32'(out_valid), 1);
      check("t4_head_holds", 32'(out_data), 32'h10);
`ifdef CNT_STREAM_DECODER_STATS_EN
      check("t4_drop_cnt", 32'(drop_cnt), 3);
`endif
      step();
      out_ready = 1'b1;
      repeat (4) step();
      check("t4_drained", 32'(out_valid), 0);
      exp_q.push_back(8'h60);
      send(8'h65, 1'b0);
      idle();
      step();
      check("t4_ovf_sticky", 32'(ovf), 1);

      // 6: clr with three buffered bytes and ovf set; sync input in clr cycle ignored
      out_ready = 1'b0;
      send(8'h06, 1'b0);
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      idle();
      check("t6_pre_valid", 32'(out_valid), 1);
      clr       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sync   = 1'b1;
      in_data   = 8'h99;
      step();
      clr       = 1'b0;
      out_ready = 1'b0;
      idle();
      check("t6_out_valid", 32'(out_valid), 0);
      check("t6_ovf", 32'(ovf), 0);
      check("t6_locked", 32'(locked), 0);
`ifdef CNT_STREAM_DECODER_STATS_EN
      check("t6_drop_cnt", 32'(drop_cnt), 0);
`endif

      // 5: full FIFO with simultaneous push and pop
      exp_q.push_back(8'h11);
      send(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      send(8'h23, 1'b0);
      exp_q.push_back(8'h33);
      send(8'h35, 1'b0);
      exp_q.push_back(8'h44);
      send(8'h47, 1'b0);
      out_ready = 1'b1;
      exp_q.push_back(8'h55);
      send(8'h59, 1'b0);
      out_ready = 1'b0;
      idle();
      check("t5_ovf", 32'(ovf), 0);
      check("t5_head", 32'(out_data), 32'h22);
      out_ready = 1'b1;
      n = 0;
      repeat (6) begin
         if (out_valid) n++;
         step();
      end
      check("t5_occupancy", 32'(n), 4);
      out_ready = 1'b0;

      // Async reset mid-stream after an overflow
      send(8'h00, 1'b1);
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      idle();
      check("rst2_pre_ovf", 32'(ovf), 1);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst2_out_valid", 32'(out_valid), 0);
      check("rst2_out_data", 32'(out_data), 0);
      check("rst2_locked", 32'(locked), 0);
      check("rst2_ovf", 32'(ovf), 0);
`ifdef CNT_STREAM_DECODER_STATS_EN
      check("rst2_drop_cnt", 32'(drop_cnt), 0);
`endif
      step();
      rst_n = 1'b1;
      step();
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
